// File: rtl/sat_pkg.sv
// Shared types for the SAT solver trail logic.
// Assignment kinds and trail controller states.
package sat_pkg;

    typedef enum logic {
        DECIDED = 1'b0,
        FORCED  = 1'b1
    } assign_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        UNWIND = 1'b1
    } trail_state_e;

endpackage

// File: rtl/trail_mem.sv
// Trail entry storage: one synchronous write port,
// one asynchronous read port, no reset on the array.
module trail_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail for a DPLL-style SAT solver: push/pop of
// {var, val, type} entries plus a multi-cycle unwind to the last decision.
module trail_stack
    import sat_pkg::*;
#(
    parameter int VAR_W = 7,
    parameter int DEPTH = 128,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             backtrack,
    input  logic [VAR_W-1:0] var_in,
    input  logic             val_in,
    input  logic             type_in,
    output logic [VAR_W-1:0] var_out,
    output logic             val_out,
    output logic             type_out,
    output logic             out_valid,
    output logic             busy,
    output logic             bt_done,
    output logic             unsat,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] level,
    output logic             err
);

    localparam int EW = VAR_W + 2;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trail_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             err_q, err_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [EW-1:0]    wdata;
    logic [AW-1:0]    raddr;
    logic [EW-1:0]    rdata;

    logic [CNT_W-1:0] top_idx;
    logic [VAR_W-1:0] top_var;
    logic             top_val;
    assign_type_e     top_type;
    logic             is_empty;
    logic             is_full;
    logic             top_dec;
    logic             in_dec;
    logic             flip;

    assign top_idx  = count_q - 1'b1;
    assign raddr    = top_idx[AW-1:0];
    assign top_var  = rdata[EW-1:2];
    assign top_val  = rdata[1];
    assign top_type = assign_type_e'(rdata[0]);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign top_dec  = !is_empty && (top_type == DECIDED);
    assign in_dec   = (type_in == DECIDED);

    trail_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        level_d = level_q;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = count_q[AW-1:0];
        wdata   = {var_in, val_in, type_in};
        unique case (state_q)
            IDLE: begin
                if (backtrack) begin
                    state_d = UNWIND;
                end else if (push && pop && !is_empty) begin
                    // Replace top in place; count is unchanged.
                    we      = 1'b1;
                    waddr   = top_idx[AW-1:0];
                    level_d = level_q - CNT_W'(top_dec)
                            + CNT_W'(in_dec);
                end else if (push) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                        level_d = level_q + CNT_W'(in_dec);
                    end
                end else if (pop) begin
                    if (is_empty) begin
                        err_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                        level_d = level_q - CNT_W'(top_dec);
                    end
                end
            end
            UNWIND: begin
                if (is_empty) begin
                    state_d = IDLE;
                end else if (top_type == FORCED) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Flip the decision and turn it into a forced entry.
                    we      = 1'b1;
                    waddr   = top_idx[AW-1:0];
                    wdata   = {top_var, ~top_val, 1'b1};
                    level_d = level_q - 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == UNWIND);
    assign out_valid = busy && !is_empty;
    assign flip      = out_valid && (top_type == DECIDED);
    assign bt_done   = flip;
    assign unsat     = busy && is_empty;

    assign var_out  = is_empty ? '0 : top_var;
    assign val_out  = is_empty ? 1'b0 : (top_val ^ flip);
    assign type_out = is_empty ? 1'b0 : (flip | rdata[0]);

    assign empty = is_empty;
    assign full  = is_full;
    assign count = count_q;
    assign level = level_q;
    assign err   = err_q;

endmodule

// File: tb/tb_trail_stack.sv
// Scoreboard bench for trail_stack: stimulus queues expected strobe
// events, a negedge monitor pops and compares them as they appear.
module tb_trail_stack;

    localparam int VAR_W = 7;
    localparam int DEPTH = 128;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             backtrack = 1'b0;
    logic [VAR_W-1:0] var_in = '0;
    logic             val_in = 1'b0;
    logic             type_in = 1'b0;
    logic [VAR_W-1:0] var_out;
    logic             val_out;
    logic             type_out;
    logic             out_valid;
    logic             busy;
    logic             bt_done;
    logic             unsat;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] level;
    logic             err;

    trail_stack #(
        .VAR_W (VAR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .backtrack (backtrack),
        .var_in    (var_in),
        .val_in    (val_in),
        .type_in   (type_in),
        .var_out   (var_out),
        .val_out   (val_out),
        .type_out  (type_out),
        .out_valid (out_valid),
        .busy      (busy),
        .bt_done   (bt_done),
        .unsat     (unsat),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .level     (level),
        .err       (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             ov;
        logic             bd;
        logic             un;
        logic             er;
        logic [VAR_W-1:0] v;
        logic             val;
        logic             typ;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic expect_ev(input logic ov, input logic bd,
                             input logic un, input logic er,
                             input int v, input logic vl,
                             input logic t);
        ev_t e;
        e.ov  = ov;
        e.bd  = bd;
        e.un  = un;
        e.er  = er;
        e.v   = VAR_W'(v);
        e.val = vl;
        e.typ = t;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the next expected event.
    always @(negedge clock) begin
        ev_t g;
        ev_t e;
        if (!reset && (out_valid || bt_done || unsat || err)) begin
            g = {out_valid, bt_done, unsat, err,
                 var_out, val_out, type_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", g);
            end else begin
                e = exp_q.pop_front();
                if (g != e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", g, e);
                end
            end
        end
    end

    task automatic do_op(input logic p, input logic q, input logic b,
                         input int v, input logic vl, input logic t);
        @(negedge clock);
        push      = p;
        pop       = q;
        backtrack = b;
        var_in    = VAR_W'(v);
        val_in    = vl;
        type_in   = t;
        @(negedge clock);
        push      = 1'b0;
        pop       = 1'b0;
        backtrack = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    int n;

    initial begin
        #12;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_count", int'(count), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_var", int'(var_out), 0);

        // Pop when empty
        expect_ev(0, 0, 0, 1, 0, 0, 0);
        do_op(0, 1, 0, 0, 0, 0);
        chk("pe_empty", int'(empty), 1);
        chk("pe_count", int'(count), 0);
        chk("pe_val", int'(val_out), 0);

        // Push then pop
        do_op(1, 0, 0, 69, 1, 1);
        chk("p69_var", int'(var_out), 69);
        chk("p69_val", int'(val_out), 1);
        chk("p69_type", int'(type_out), 1);
        chk("p69_count", int'(count), 1);
        chk("p69_level", int'(level), 0);
        do_op(0, 1, 0, 0, 0, 0);
        chk("p69_empty", int'(empty), 1);
        chk("p69_level2", int'(level), 0);

        // Backtrack to a decision
        do_op(1, 0, 0, 12, 0, 0);
        chk("d12_level", int'(level), 1);
        do_op(1, 0, 0, 13, 1, 1);
        do_op(1, 0, 0, 14, 1, 1);
        chk("bt_count0", int'(count), 3);
        expect_ev(1, 0, 0, 0, 14, 1, 1);
        expect_ev(1, 0, 0, 0, 13, 1, 1);
        expect_ev(1, 1, 0, 0, 12, 1, 1);
        do_op(0, 0, 1, 0, 0, 0);
        chk("bt_busy", int'(busy), 1);
        wait_idle(n);
        chk("bt_cycles", n, 3);
        chk("bt_count", int'(count), 1);
        chk("bt_level", int'(level), 0);
        chk("bt_var", int'(var_out), 12);
        chk("bt_val", int'(val_out), 1);
        chk("bt_type", int'(type_out), 1);
        do_op(0, 1, 0, 0, 0, 0);
        chk("bt_empty", int'(empty), 1);

        // Backtrack with no decision -> unsat
        do_op(1, 0, 0, 15, 0, 1);
        do_op(1, 0, 0, 16, 1, 1);
        expect_ev(1, 0, 0, 0, 16, 1, 1);
        expect_ev(1, 0, 0, 0, 15, 0, 1);
        expect_ev(0, 0, 1, 0, 0, 0, 0);
        do_op(0, 0, 1, 0, 0, 0);
        wait_idle(n);
        chk("us_cycles", n, 3);
        chk("us_empty", int'(empty), 1);
        chk("us_level", int'(level), 0);

        // Push+pop: empty acts as push, otherwise replaces top
        do_op(1, 1, 0, 20, 1, 0);
        chk("pp_count1", int'(count), 1);
        chk("pp_level1", int'(level), 1);
        do_op(1, 1, 0, 21, 0, 1);
        chk("pp_count2", int'(count), 1);
        chk("pp_level2", int'(level), 0);
        chk("pp_var", int'(var_out), 21);
        do_op(0, 1, 0, 0, 0, 0);

        // Fill to capacity: every 4th entry is a decision
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1, 0, 0, i, i[0], (i % 4) != 0);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        chk("fill_level", int'(level), DEPTH / 4);
        expect_ev(0, 0, 0, 1, DEPTH - 1, 1, 1);
        do_op(1, 0, 0, 5, 0, 0);
        chk("ovf_count", int'(count), DEPTH);
        chk("ovf_full", int'(full), 1);
        do_op(1, 1, 0, 99, 1, 0);
        chk("fpp_count", int'(count), DEPTH);
        chk("fpp_level", int'(level), DEPTH / 4 + 1);
        chk("fpp_var", int'(var_out), 99);

        // Reset in the middle of an unwind
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        do_op(1, 0, 0, 12, 0, 0);
        do_op(1, 0, 0, 13, 1, 1);
        do_op(1, 0, 0, 14, 1, 1);
        expect_ev(1, 0, 0, 0, 14, 1, 1);
        do_op(0, 0, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ra_count", int'(count), 0);
        chk("ra_busy", int'(busy), 0);
        chk("ra_bt_done", int'(bt_done), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("ra_empty", int'(empty), 1);
        chk("ra_level", int'(level), 0);

        chk("leftover_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
